dcm_supervisor: RTL and testbench

DCM_SUPERVISOR -- requirements
Module: dcm_supervisor

---
 rtl/dcm_supervisor.sv | 166 ++++++++++++++++
 tb/tb_dcm_supervisor.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/dcm_supervisor.sv
// Supervises NCH DCM instances: pulses each DCM reset, waits for a stable lock,
// flags the output clock ready, and retries a bounded number of times before faulting.
module dcm_supervisor #(
  parameter int unsigned NCH           = 1,
  parameter int unsigned RST_CYCLES    = 3,
  parameter int unsigned LOCK_TIMEOUT  = 65535,
  parameter int unsigned STABLE_CYCLES = 16,
  parameter int unsigned MAX_RETRY     = 7
) (
  input  logic           Clk,
  input  logic           RstN,
  input  logic [NCH-1:0] DcmLocked,
  input  logic [NCH-1:0] DcmClkFxStopped,
  output logic [NCH-1:0] DcmRst,
  output logic [NCH-1:0] ClkRdy,
  output logic [NCH-1:0] Fault,
  output logic           AllRdy
);

  localparam int unsigned CNT_MAX_A = (RST_CYCLES > STABLE_CYCLES) ? RST_CYCLES : STABLE_CYCLES;
  localparam int unsigned CNT_MAX   = (CNT_MAX_A > LOCK_TIMEOUT) ? CNT_MAX_A : LOCK_TIMEOUT;
  localparam int unsigned CW        = $clog2(CNT_MAX);
  localparam int unsigned RW        = (MAX_RETRY == 0) ? 1 : $clog2(MAX_RETRY + 1);

  typedef enum logic [2:0] {
    ST_RESET,
    ST_WAIT_LOCK,
    ST_STABLE,
    ST_RUN,
    ST_FAULT
  } state_t;

  logic [NCH-1:0] lockM;
  logic [NCH-1:0] lockS;
  logic [NCH-1:0] stopM;
  logic [NCH-1:0] stopS;
  logic           runEn;

  // Two-flop synchronisers for the asynchronous DCM status inputs.
  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      lockM <= '0;
      lockS <= '0;
      stopM <= '0;
      stopS <= '0;
    end else begin
      lockM <= DcmLocked;
      lockS <= lockM;
      stopM <= DcmClkFxStopped;
      stopS <= stopM;
    end
  end

  // Release flop: the first edge after RstN rises only arms the FSMs, so the
  // reset pulse counts whole cycles from that edge.
  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      runEn <= 1'b0;
    end else begin
      runEn <= 1'b1;
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : gCh
    state_t        state;
    state_t        stateNxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cntNxt;
    logic [RW-1:0] retry;
    logic [RW-1:0] retryNxt;
    logic          good;
    logic          fail;
    logic          rstQ;
    logic          rdyQ;
    logic          faultQ;

    assign good = lockS[g] & ~stopS[g];

    always_ff @(posedge Clk or negedge RstN) begin
      if (!RstN) begin
        state  <= ST_RESET;
        cnt    <= '0;
        retry  <= '0;
        rstQ   <= 1'b1;
        rdyQ   <= 1'b0;
        faultQ <= 1'b0;
      end else if (runEn) begin
        state  <= stateNxt;
        cnt    <= cntNxt;
        retry  <= retryNxt;
        rstQ   <= (stateNxt == ST_RESET);
        rdyQ   <= (stateNxt == ST_RUN);
        faultQ <= (stateNxt == ST_FAULT);
      end
    end

    always_comb begin
      stateNxt = state;
      cntNxt   = cnt;
      retryNxt = retry;
      fail     = 1'b0;
      case (state)
        ST_RESET: begin
          if (cnt == CW'(RST_CYCLES - 1)) begin
            stateNxt = ST_WAIT_LOCK;
            cntNxt   = '0;
          end else begin
            cntNxt = cnt + 1'b1;
          end
        end
        ST_WAIT_LOCK: begin
          // Lock is tested before timeout so a lock on the last cycle still counts.
          if (good) begin
            stateNxt = ST_STABLE;
            cntNxt   = '0;
          end else if (cnt == CW'(LOCK_TIMEOUT - 1)) begin
            fail = 1'b1;
          end else begin
            cntNxt = cnt + 1'b1;
          end
        end
        ST_STABLE: begin
          if (!good) begin
            fail = 1'b1;
          end else if (cnt == CW'(STABLE_CYCLES - 1)) begin
            stateNxt = ST_RUN;
            cntNxt   = '0;
            retryNxt = '0;
          end else begin
            cntNxt = cnt + 1'b1;
          end
        end
        ST_RUN: begin
          if (!good) begin
            stateNxt = ST_RESET;
            cntNxt   = '0;
          end
        end
        ST_FAULT: begin
          stateNxt = ST_FAULT;
        end
        default: begin
          stateNxt = ST_RESET;
          cntNxt   = '0;
        end
      endcase

      if (fail) begin
        cntNxt = '0;
        if (retry == RW'(MAX_RETRY)) begin
          stateNxt = ST_FAULT;
        end else begin
          retryNxt = retry + 1'b1;
          stateNxt = ST_RESET;
        end
      end
    end

    assign DcmRst[g] = rstQ;
    assign ClkRdy[g] = rdyQ;
    assign Fault[g]  = faultQ;
  end

  assign AllRdy = &ClkRdy;

endmodule

// File: tb/tb_dcm_supervisor.sv
// Directed, table-driven bench for dcm_supervisor with NCH=2 and short timing parameters.
module tb_dcm_supervisor;

  localparam int unsigned NCH = 2;

  logic           Clk;
  logic           RstN;
  logic [NCH-1:0] DcmLocked;
  logic [NCH-1:0] DcmClkFxStopped;
  logic [NCH-1:0] DcmRst;
  logic [NCH-1:0] ClkRdy;
  logic [NCH-1:0] Fault;
  logic           AllRdy;

  int errors;
  int checks;
  int cyc;

  typedef struct {
    logic       newRun;
    int         cyc;
    logic [1:0] lock;
    logic [1:0] stop;
    logic [1:0] eRst;
    logic [1:0] eRdy;
    logic [1:0] eFault;
  } vec_t;

  vec_t vecs[$];

  dcm_supervisor #(
    .NCH(NCH),
    .RST_CYCLES(3),
    .LOCK_TIMEOUT(20),
    .STABLE_CYCLES(4),
    .MAX_RETRY(2)
  ) dut (
    .Clk(Clk),
    .RstN(RstN),
    .DcmLocked(DcmLocked),
    .DcmClkFxStopped(DcmClkFxStopped),
    .DcmRst(DcmRst),
    .ClkRdy(ClkRdy),
    .Fault(Fault),
    .AllRdy(AllRdy)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached, required end of test");
    $fatal(1, "watchdog");
  end

  function automatic vec_t v(input logic n, input int c, input logic [1:0] lk, input logic [1:0] st,
                             input logic [1:0] er, input logic [1:0] ed, input logic [1:0] ef);
    vec_t r;
    r.newRun = n;
    r.cyc    = c;
    r.lock   = lk;
    r.stop   = st;
    r.eRst   = er;
    r.eRdy   = ed;
    r.eFault = ef;
    return r;
  endfunction

  task automatic tick();
    @(posedge Clk);
    #1;
    cyc++;
  endtask

  task automatic check(input string name, input logic [1:0] eRst, input logic [1:0] eRdy,
                       input logic [1:0] eFault);
    logic eAll;
    eAll = &eRdy;
    checks++;
    if (DcmRst !== eRst || ClkRdy !== eRdy || Fault !== eFault || AllRdy !== eAll) begin
      errors++;
      $display("FAIL %s: got Rst=%b Rdy=%b Fault=%b All=%b, required Rst=%b Rdy=%b Fault=%b All=%b",
               name, DcmRst, ClkRdy, Fault, AllRdy, eRst, eRdy, eFault, eAll);
    end
  endtask

  // Asserts RstN between edges, checks the asynchronous reset values, then
  // releases on a falling edge; the next rising edge is cycle 0.
  task automatic doReset();
    RstN            = 1'b0;
    DcmLocked       = '0;
    DcmClkFxStopped = '0;
    #2;
    check("resetAsync", 2'b11, 2'b00, 2'b00);
    @(negedge Clk);
    RstN = 1'b1;
    cyc  = -1;
  endtask

  initial begin
    errors          = 0;
    checks          = 0;
    cyc             = -1;
    RstN            = 1'b1;
    DcmLocked       = '0;
    DcmClkFxStopped = '0;

    // Channel 0 never locks and faults after three attempts; channel 1 locks from cycle 5.
    vecs.push_back(v(1'b1,  0, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00));
    vecs.push_back(v(1'b0,  2, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00));
    vecs.push_back(v(1'b0,  3, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
    vecs.push_back(v(1'b0,  5, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00));
    vecs.push_back(v(1'b0, 11, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00));
    vecs.push_back(v(1'b0, 12, 2'b10, 2'b00, 2'b00, 2'b10, 2'b00));
    vecs.push_back(v(1'b0, 22, 2'b10, 2'b00, 2'b00, 2'b10, 2'b00));
    vecs.push_back(v(1'b0, 23, 2'b10, 2'b00, 2'b01, 2'b10, 2'b00));
    vecs.push_back(v(1'b0, 25, 2'b10, 2'b00, 2'b01, 2'b10, 2'b00));
    vecs.push_back(v(1'b0, 26, 2'b10, 2'b00, 2'b00, 2'b10, 2'b00));
    vecs.push_back(v(1'b0, 46, 2'b10, 2'b00, 2'b01, 2'b10, 2'b00));
    vecs.push_back(v(1'b0, 48, 2'b10, 2'b00, 2'b01, 2'b10, 2'b00));
    vecs.push_back(v(1'b0, 49, 2'b10, 2'b00, 2'b00, 2'b10, 2'b00));
    vecs.push_back(v(1'b0, 68, 2'b10, 2'b00, 2'b00, 2'b10, 2'b00));
    vecs.push_back(v(1'b0, 69, 2'b10, 2'b00, 2'b00, 2'b10, 2'b01));
    vecs.push_back(v(1'b0, 75, 2'b10, 2'b00, 2'b00, 2'b10, 2'b01));
    // Reset from FAULT/RUN; both lock; channel 1 loses its FX clock during RUN and relocks.
    vecs.push_back(v(1'b1,  0, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00));
    vecs.push_back(v(1'b0,  2, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00));
    vecs.push_back(v(1'b0,  3, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
    vecs.push_back(v(1'b0,  5, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00));
    vecs.push_back(v(1'b0, 11, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00));
    vecs.push_back(v(1'b0, 12, 2'b11, 2'b00, 2'b00, 2'b11, 2'b00));
    vecs.push_back(v(1'b0, 15, 2'b11, 2'b10, 2'b00, 2'b11, 2'b00));
    vecs.push_back(v(1'b0, 17, 2'b11, 2'b10, 2'b00, 2'b11, 2'b00));
    vecs.push_back(v(1'b0, 18, 2'b11, 2'b00, 2'b10, 2'b01, 2'b00));
    vecs.push_back(v(1'b0, 20, 2'b11, 2'b00, 2'b10, 2'b01, 2'b00));
    vecs.push_back(v(1'b0, 21, 2'b11, 2'b00, 2'b00, 2'b01, 2'b00));
    vecs.push_back(v(1'b0, 25, 2'b11, 2'b00, 2'b00, 2'b01, 2'b00));
    vecs.push_back(v(1'b0, 26, 2'b11, 2'b00, 2'b00, 2'b11, 2'b00));
    // Reset from RUN; one-cycle lock glitch on channel 0 while STABLE.
    vecs.push_back(v(1'b1,  0, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00));
    vecs.push_back(v(1'b0,  5, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00));
    vecs.push_back(v(1'b0,  8, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00));
    vecs.push_back(v(1'b0,  9, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00));
    vecs.push_back(v(1'b0, 10, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00));
    vecs.push_back(v(1'b0, 11, 2'b11, 2'b00, 2'b01, 2'b00, 2'b00));
    vecs.push_back(v(1'b0, 12, 2'b11, 2'b00, 2'b01, 2'b10, 2'b00));
    vecs.push_back(v(1'b0, 13, 2'b11, 2'b00, 2'b01, 2'b10, 2'b00));
    vecs.push_back(v(1'b0, 14, 2'b11, 2'b00, 2'b00, 2'b10, 2'b00));
    vecs.push_back(v(1'b0, 18, 2'b11, 2'b00, 2'b00, 2'b10, 2'b00));
    vecs.push_back(v(1'b0, 19, 2'b11, 2'b00, 2'b00, 2'b11, 2'b00));
    // Channel 1 loses lock on its final STABLE cycle; channel 0 locks exactly at timeout.
    vecs.push_back(v(1'b1,  0, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00));
    vecs.push_back(v(1'b0,  5, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00));
    vecs.push_back(v(1'b0,  9, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
    vecs.push_back(v(1'b0, 10, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00));
    vecs.push_back(v(1'b0, 11, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00));
    vecs.push_back(v(1'b0, 12, 2'b10, 2'b00, 2'b10, 2'b00, 2'b00));
    vecs.push_back(v(1'b0, 14, 2'b10, 2'b00, 2'b10, 2'b00, 2'b00));
    vecs.push_back(v(1'b0, 15, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00));
    vecs.push_back(v(1'b0, 19, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00));
    vecs.push_back(v(1'b0, 20, 2'b11, 2'b00, 2'b00, 2'b10, 2'b00));
    vecs.push_back(v(1'b0, 22, 2'b11, 2'b00, 2'b00, 2'b10, 2'b00));
    vecs.push_back(v(1'b0, 23, 2'b11, 2'b00, 2'b00, 2'b10, 2'b00));
    vecs.push_back(v(1'b0, 26, 2'b11, 2'b00, 2'b00, 2'b10, 2'b00));
    vecs.push_back(v(1'b0, 27, 2'b11, 2'b00, 2'b00, 2'b11, 2'b00));

    #1;
    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].newRun) doReset();
      while (cyc < vecs[i].cyc) tick();
      check($sformatf("vec%0d@c%0d", i, cyc), vecs[i].eRst, vecs[i].eRdy, vecs[i].eFault);
      DcmLocked       = vecs[i].lock;
      DcmClkFxStopped = vecs[i].stop;
    end

    // Reset out of the all-running state must also be immediate.
    doReset();
    tick();
    check("postReleaseC0", 2'b11, 2'b00, 2'b00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
